me_sprite_seq: RTL and testbench

Image sequencer for the player craft sprite, in the `clk_vga` domain. It decodes the 22-bit `bram_me` word (two normal frames with alpha, plus three destroy frames). It chooses which frame is shown on each video frame: normal animation, a hit-triggered destroy sequence, then dead. It drives the craft's layer RGB/alpha into the pixel compositor, and the resulting `alive_o`/`dead_pulse_o` feed game control.

---
 rtl/me_sprite_seq.sv | 155 +++++++++++++++
 tb/tb_me_sprite_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/me_sprite_seq.sv
// Player craft sprite sequencer: picks the normal/destroy image once per video frame
// and turns the 22-bit bram_me word into layer RGB/alpha for the pixel compositor.
module me_sprite_seq #(
  parameter int NORMAL_DIV  = 8,
  parameter int DESTROY_DIV = 6,
  parameter int GRAY_W      = 4,
  parameter int INFO_W      = 5*GRAY_W+2
) (
  input  logic                  clk_vga,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic                  v_sync_i,
  input  logic                  hit_i,
  input  logic                  revive_i,
  input  logic                  pix_valid_i,
  input  logic [INFO_W-1:0]     bram_info_i,
  output logic [3*GRAY_W-1:0]   vga_rgb_o,
  output logic                  vga_alpha_o,
  output logic                  alive_o,
  output logic                  destroying_o,
  output logic                  dead_pulse_o
);

  localparam int MAX_DIV = (NORMAL_DIV > DESTROY_DIV) ? NORMAL_DIV : DESTROY_DIV;
  localparam int FCNT_W  = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;
  localparam logic [FCNT_W-1:0] N_LAST = FCNT_W'(NORMAL_DIV - 1);
  localparam logic [FCNT_W-1:0] D_LAST = FCNT_W'(DESTROY_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_NORMAL, S_D1, S_D2, S_D3, S_DEAD
  } state_t;

  state_t              state;
  logic                img;
  logic [FCNT_W-1:0]   fcnt;
  logic                hit_pend;
  logic                rev_pend;
  logic                vs_q;
  logic                tick;

  // BRAM word fields, MSB first: {alpha1, gray1, alpha2, gray2, gd1, gd2, gd3}
  logic                alpha1, alpha2;
  logic [GRAY_W-1:0]   gray1, gray2, gd1, gd2, gd3;

  assign alpha1 = bram_info_i[INFO_W-1];
  assign gray1  = bram_info_i[INFO_W-2 -: GRAY_W];
  assign alpha2 = bram_info_i[INFO_W-2-GRAY_W];
  assign gray2  = bram_info_i[INFO_W-3-GRAY_W -: GRAY_W];
  assign gd1    = bram_info_i[3*GRAY_W-1 -: GRAY_W];
  assign gd2    = bram_info_i[2*GRAY_W-1 -: GRAY_W];
  assign gd3    = bram_info_i[GRAY_W-1:0];

  // Vsync is active-low; the frame boundary is its release (0 -> 1).
  assign tick = v_sync_i & ~vs_q;

  assign alive_o      = (state == S_NORMAL);
  assign destroying_o = (state == S_D1) || (state == S_D2) || (state == S_D3);

  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      img          <= 1'b0;
      fcnt         <= '0;
      hit_pend     <= 1'b0;
      rev_pend     <= 1'b0;
      vs_q         <= 1'b1;
      dead_pulse_o <= 1'b0;
    end else begin
      vs_q         <= v_sync_i;
      dead_pulse_o <= 1'b0;
      if (!en_i) begin
        state    <= S_IDLE;
        img      <= 1'b0;
        fcnt     <= '0;
        hit_pend <= 1'b0;
        rev_pend <= 1'b0;
      end else begin
        if (state == S_NORMAL && hit_i)  hit_pend <= 1'b1;
        if (state == S_DEAD && revive_i) rev_pend <= 1'b1;
        case (state)
          S_IDLE: begin
            hit_pend <= 1'b0;
            rev_pend <= 1'b0;
            if (tick) begin
              state <= S_NORMAL;
              img   <= 1'b0;
              fcnt  <= '0;
            end
          end
          S_NORMAL: if (tick) begin
            if (hit_pend || hit_i) begin
              state    <= S_D1;
              fcnt     <= '0;
              hit_pend <= 1'b0;
            end else if (fcnt == N_LAST) begin
              img  <= ~img;
              fcnt <= '0;
            end else begin
              fcnt <= fcnt + FCNT_W'(1);
            end
          end
          S_D1, S_D2, S_D3: if (tick) begin
            if (fcnt == D_LAST) begin
              fcnt  <= '0;
              state <= (state == S_D1) ? S_D2 : (state == S_D2) ? S_D3 : S_DEAD;
              if (state == S_D3) dead_pulse_o <= 1'b1;
            end else begin
              fcnt <= fcnt + FCNT_W'(1);
            end
          end
          S_DEAD: if (tick && (rev_pend || revive_i)) begin
            state    <= S_NORMAL;
            img      <= 1'b0;
            fcnt     <= '0;
            rev_pend <= 1'b0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  logic [GRAY_W-1:0] sel_gray;
  logic              sel_alpha;

  always_comb begin
    sel_gray  = '0;
    sel_alpha = 1'b0;
    case (state)
      S_NORMAL: begin
        sel_gray  = img ? gray2  : gray1;
        sel_alpha = img ? alpha2 : alpha1;
      end
      S_D1: begin sel_gray = gd1; sel_alpha = |gd1; end
      S_D2: begin sel_gray = gd2; sel_alpha = |gd2; end
      S_D3: begin sel_gray = gd3; sel_alpha = |gd3; end
      default: ;
    endcase
  end

  // pix_valid_i qualifies bram_info_i for this cycle only; no backpressure exists.
  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      vga_rgb_o   <= '0;
      vga_alpha_o <= 1'b0;
    end else if (!en_i || !pix_valid_i) begin
      vga_rgb_o   <= '0;
      vga_alpha_o <= 1'b0;
    end else begin
      vga_rgb_o   <= {3{sel_gray}};
      vga_alpha_o <= sel_alpha;
    end
  end

endmodule

// File: tb/tb_me_sprite_seq.sv
// Directed bench for me_sprite_seq: normal animation, destroy sequence, revive,
// enable drop and asynchronous reset, with hand-computed expected pixels.
module tb_me_sprite_seq;

  logic        clk_vga = 1'b0;
  logic        rst;
  logic        en_i;
  logic        v_sync_i;
  logic        hit_i;
  logic        revive_i;
  logic        pix_valid_i;
  logic [21:0] bram_info_i;
  logic [11:0] vga_rgb_o;
  logic        vga_alpha_o;
  logic        alive_o;
  logic        destroying_o;
  logic        dead_pulse_o;

  int checks   = 0;
  int failures = 0;

  // alpha1=1 gray1=A alpha2=1 gray2=5 gd1=3 gd2=0 gd3=C
  localparam logic [21:0] WORD = {1'b1, 4'hA, 1'b1, 4'h5, 4'h3, 4'h0, 4'hC};

  me_sprite_seq dut (
    .clk_vga      (clk_vga),
    .rst          (rst),
    .en_i         (en_i),
    .v_sync_i     (v_sync_i),
    .hit_i        (hit_i),
    .revive_i     (revive_i),
    .pix_valid_i  (pix_valid_i),
    .bram_info_i  (bram_info_i),
    .vga_rgb_o    (vga_rgb_o),
    .vga_alpha_o  (vga_alpha_o),
    .alive_o      (alive_o),
    .destroying_o (destroying_o),
    .dead_pulse_o (dead_pulse_o)
  );

  always #5 clk_vga = ~clk_vga;

  task automatic step();
    @(posedge clk_vga);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Leaves the bench #1 after the tick edge.
  task automatic tick_edge();
    v_sync_i = 1'b0;
    step();
    v_sync_i = 1'b1;
    step();
  endtask

  task automatic tick_chk(input string tag, input logic pulse, input logic [11:0] rgb,
                          input logic alpha, input logic alive, input logic destr);
    tick_edge();
    chk({tag, "_pulse"}, {31'd0, dead_pulse_o}, {31'd0, pulse});
    step();
    chk({tag, "_rgb"},   {20'd0, vga_rgb_o},    {20'd0, rgb});
    chk({tag, "_alpha"}, {31'd0, vga_alpha_o},  {31'd0, alpha});
    chk({tag, "_alive"}, {31'd0, alive_o},      {31'd0, alive});
    chk({tag, "_destr"}, {31'd0, destroying_o}, {31'd0, destr});
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_rgb"},   {20'd0, vga_rgb_o},    32'd0);
    chk({tag, "_alpha"}, {31'd0, vga_alpha_o},  32'd0);
    chk({tag, "_alive"}, {31'd0, alive_o},      32'd0);
    chk({tag, "_destr"}, {31'd0, destroying_o}, 32'd0);
    chk({tag, "_pulse"}, {31'd0, dead_pulse_o}, 32'd0);
  endtask

  initial begin
    // Clock/reset
    rst = 1'b1; en_i = 1'b1; v_sync_i = 1'b1; hit_i = 1'b0; revive_i = 1'b0;
    pix_valid_i = 1'b1; bram_info_i = WORD;
    repeat (3) step();
    rst = 1'b0;
    step();
    check_idle_outputs("reset");

    // Normal animation: image toggles at ticks 9 and 17
    tick_chk("norm1", 1'b0, 12'hAAA, 1'b1, 1'b1, 1'b0);
    for (int t = 2; t <= 20; t++)
      tick_chk($sformatf("norm%0d", t), 1'b0,
               (t < 9 || t >= 17) ? 12'hAAA : 12'h555, 1'b1, 1'b1, 1'b0);

    // pix_valid gating, one cycle latency
    pix_valid_i = 1'b0;
    step();
    chk("pv0_rgb",   {20'd0, vga_rgb_o},   32'd0);
    chk("pv0_alpha", {31'd0, vga_alpha_o}, 32'd0);
    bram_info_i = 22'h3FFFFF;
    step();
    chk("pv0_any_rgb", {20'd0, vga_rgb_o}, 32'd0);
    pix_valid_i = 1'b1;
    bram_info_i = WORD;
    step();
    chk("pv1_rgb", {20'd0, vga_rgb_o}, 32'hAAA);

    // Mid-frame hit: image holds until the next tick
    hit_i = 1'b1;
    step();
    hit_i = 1'b0;
    repeat (2) step();
    chk("hit_hold_rgb",   {20'd0, vga_rgb_o}, 32'hAAA);
    chk("hit_hold_alive", {31'd0, alive_o},   32'd1);
    tick_chk("d1_entry", 1'b0, 12'h333, 1'b1, 1'b0, 1'b1);
    for (int t = 1; t <= 18; t++) begin
      if (t == 8) begin
        hit_i = 1'b1;   // ignored in D2
        step();
        hit_i = 1'b0;
      end
      if (t < 6)       tick_chk($sformatf("dseq%0d", t), 1'b0, 12'h333, 1'b1, 1'b0, 1'b1);
      else if (t < 12) tick_chk($sformatf("dseq%0d", t), 1'b0, 12'h000, 1'b0, 1'b0, 1'b1);
      else if (t < 18) tick_chk($sformatf("dseq%0d", t), 1'b0, 12'hCCC, 1'b1, 1'b0, 1'b1);
      else             tick_chk("dead_entry",            1'b1, 12'h000, 1'b0, 1'b0, 1'b0);
    end
    tick_chk("dead_hold", 1'b0, 12'h000, 1'b0, 1'b0, 1'b0);

    // Revive pulse mid-frame in DEAD
    revive_i = 1'b1;
    step();
    revive_i = 1'b0;
    step();
    chk("rev_wait_alive", {31'd0, alive_o}, 32'd0);
    tick_chk("revive", 1'b0, 12'hAAA, 1'b1, 1'b1, 1'b0);

    // Revive in NORMAL does nothing
    revive_i = 1'b1;
    step();
    revive_i = 1'b0;
    tick_chk("rev_norm", 1'b0, 12'hAAA, 1'b1, 1'b1, 1'b0);

    // Hit on the tick cycle itself
    v_sync_i = 1'b0;
    step();
    v_sync_i = 1'b1;
    hit_i = 1'b1;
    step();
    hit_i = 1'b0;
    chk("hit_on_tick_destr", {31'd0, destroying_o}, 32'd1);
    step();
    chk("hit_on_tick_rgb", {20'd0, vga_rgb_o}, 32'h333);
    for (int t = 1; t <= 6; t++)
      tick_chk($sformatf("d2run%0d", t), 1'b0, (t < 6) ? 12'h333 : 12'h000,
               (t < 6), 1'b0, 1'b1);

    // Enable dropped in D2
    en_i = 1'b0;
    step();
    check_idle_outputs("en_drop");
    for (int t = 1; t <= 14; t++) begin
      tick_edge();
      chk($sformatf("en_off_pulse%0d", t), {31'd0, dead_pulse_o}, 32'd0);
    end
    step();
    check_idle_outputs("en_off");
    en_i = 1'b1;
    tick_chk("en_back", 1'b0, 12'hAAA, 1'b1, 1'b1, 1'b0);

    // Async reset mid-D3
    hit_i = 1'b1;
    step();
    hit_i = 1'b0;
    tick_chk("d1_again", 1'b0, 12'h333, 1'b1, 1'b0, 1'b1);
    for (int t = 1; t <= 12; t++)
      tick_chk($sformatf("to_d3_%0d", t), 1'b0,
               (t < 6) ? 12'h333 : (t < 12) ? 12'h000 : 12'hCCC,
               (t < 6) || (t >= 12), 1'b0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_idle_outputs("async_rst");
    step();
    rst = 1'b0;
    for (int t = 1; t <= 7; t++) begin
      tick_edge();
      chk($sformatf("post_rst_pulse%0d", t), {31'd0, dead_pulse_o}, 32'd0);
      chk($sformatf("post_rst_alive%0d", t), {31'd0, alive_o}, 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
